sysfeeder: RTL and testbench

//  Transmit side of the systolic-array operand stream protocol (value/valid/end).

---
 rtl/sysfeeder_if.sv | 31 +++
 rtl/sysfeeder.sv | 157 +++++++++++++++
 tb/tb_sysfeeder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysfeeder_if.sv
// Operand-stream bundle: load handshake into the feeder and
// value/valid/end stream out to the edge PE.
`timescale 1ns/1ps
interface sysfeeder_if #(
  parameter int WL = 32
);
  logic          load_valid;
  logic [WL-1:0] load_data;
  logic          load_ready;
  logic [WL-1:0] streamvalue;
  logic          streamvalid;
  logic          streamend;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  streamvalue,
    input  streamvalid,
    input  streamend
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output streamvalue,
    output streamvalid,
    output streamend
  );
endinterface

// File: rtl/sysfeeder.sv
// Systolic operand feeder: buffers one vector, replays it
// cfg_rep times with accumulate flags, then a skew delay line.
`timescale 1ns/1ps
module sysfeeder #(
  parameter  int WL     = 32,
  parameter  int MAXLEN = 16,
  parameter  int SKEW   = 0,
  parameter  int RW     = 8,
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic [RW-1:0] cfg_rep,
  output logic          busy,
  output logic          done,
  output logic          err,
  sysfeeder_if.slave    bus
);

  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int DW = $clog2(SKEW + 2);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] LEN_TWO = LW'(2);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);
  localparam logic [RW-1:0] REP_ONE = RW'(1);
  localparam logic [DW-1:0] DRN_ONE = DW'(1);
  localparam logic [DW-1:0] DRN_END = DW'(SKEW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_e;

  state_e        state_q;
  logic [LW-1:0] wptr_q;
  logic [LW-1:0] rptr_q;
  logic [LW-1:0] len_q;
  logic [RW-1:0] rep_q;
  logic [RW-1:0] rep_cnt_q;
  logic [DW-1:0] drn_q;
  logic          done_q;
  logic          err_q;

  logic [WL-1:0] val_q [SKEW+1];
  logic [SKEW:0] vld_q;
  logic [SKEW:0] end_q;

  logic [WL-1:0] buf_q [MAXLEN];

  logic idle;
  logic ld_rdy;
  logic accept;
  logic bad_cfg;
  logic last_word;
  logic last_rep;

  assign idle      = (state_q == S_IDLE);
  assign ld_rdy    = rst_n & idle & (wptr_q < LEN_MAX) & ~start;
  assign accept    = ena & bus.load_valid & ld_rdy;
  assign bad_cfg   = (cfg_len < LEN_TWO) | (cfg_len > wptr_q)
                   | (cfg_rep == '0);
  assign last_word = (rptr_q == (len_q - LEN_ONE));
  assign last_rep  = ((rep_cnt_q + REP_ONE) == rep_q);

  // RAM is not reset; it is always rewritten before a job reads it
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[wptr_q[AW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      rep_cnt_q <= '0;
      drn_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= '0;
      end_q     <= '0;
      for (int i = 0; i <= SKEW; i++) begin
        val_q[i] <= '0;
      end
    end else if (ena) begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      val_q[0] <= '0;
      vld_q[0] <= 1'b0;
      end_q[0] <= 1'b0;
      for (int i = 1; i <= SKEW; i++) begin
        val_q[i] <= val_q[i-1];
        vld_q[i] <= vld_q[i-1];
        end_q[i] <= end_q[i-1];
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (bad_cfg) begin
              err_q <= 1'b1;
            end else begin
              len_q     <= cfg_len;
              rep_q     <= cfg_rep;
              rptr_q    <= '0;
              rep_cnt_q <= '0;
              drn_q     <= '0;
              state_q   <= S_STREAM;
            end
          end else if (accept) begin
            wptr_q <= wptr_q + LEN_ONE;
          end
        end
        S_STREAM: begin
          val_q[0] <= buf_q[rptr_q[AW-1:0]];
          vld_q[0] <= 1'b1;
          // word 0 of every pass drops end to open a new sum
          end_q[0] <= (rptr_q != '0);
          if (last_word) begin
            rptr_q    <= '0;
            rep_cnt_q <= rep_cnt_q + REP_ONE;
            if (last_rep) begin
              state_q <= S_DRAIN;
            end
          end else begin
            rptr_q <= rptr_q + LEN_ONE;
          end
        end
        S_DRAIN: begin
          if (drn_q == DRN_END) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            wptr_q  <= '0;
          end else begin
            drn_q <= drn_q + DRN_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready  = ld_rdy;
  assign bus.streamvalue = val_q[SKEW];
  assign bus.streamvalid = vld_q[SKEW];
  assign bus.streamend   = end_q[SKEW];
  assign busy            = ~idle;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sysfeeder.sv
// Directed bench: one feeder without skew and one with SKEW=3,
// both driven by the same load/control stimulus.
`timescale 1ns/1ps
module tb_sysfeeder;
  localparam int WL = 32;
  localparam int ML = 16;
  localparam int RW = 8;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [RW-1:0] cfg_rep = '0;
  logic          busy0, done0, err0;
  logic          busy3, done3, err3;
  int            tests = 0;
  int            fails = 0;

  sysfeeder_if #(.WL(WL)) b0 ();
  sysfeeder_if #(.WL(WL)) b3 ();

  assign b3.load_valid = b0.load_valid;
  assign b3.load_data  = b0.load_data;

  always #5 clk = ~clk;

  sysfeeder #(.WL(WL), .MAXLEN(ML), .SKEW(0), .RW(RW)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .cfg_len(cfg_len), .cfg_rep(cfg_rep),
    .busy(busy0), .done(done0), .err(err0), .bus(b0.slave)
  );

  sysfeeder #(.WL(WL), .MAXLEN(ML), .SKEW(3), .RW(RW)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .cfg_len(cfg_len), .cfg_rep(cfg_rep),
    .busy(busy3), .done(done3), .err(err3), .bus(b3.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WL-1:0] d);
    b0.load_valid = 1'b1;
    b0.load_data  = d;
    tick();
    b0.load_valid = 1'b0;
  endtask

  task automatic kick(input int len, input int rep);
    cfg_len = LW'(len);
    cfg_rep = RW'(rep);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy3) && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (busy0 || busy3) begin
      fails++;
      $display("FAIL idle_timeout busy0=%0b busy3=%0b required 0",
               busy0, busy3);
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    b0.load_valid = 1'b0;
    b0.load_data  = '0;
    #3;
    got = {b0.streamvalid, b0.streamend, |b0.streamvalue, busy0, done0,
           b3.streamvalid, b3.streamend, |b3.streamvalue, busy3,
           b0.load_ready};
    tests++;
    if (got !== 10'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b required 0", got);
    end
    #20;
    rst_n = 1'b1;
    tick();
    tests++;
    if ({b0.load_ready, b3.load_ready, busy0, err0} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_release got=%b required 1100",
               {b0.load_ready, b3.load_ready, busy0, err0});
    end
  endtask

  task automatic test_single();
    logic [WL+2:0] got, exp;
    for (int i = 1; i <= 4; i++) load(WL'(i));
    kick(4, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      got = {b0.streamvalue, b0.streamvalid, b0.streamend, done0};
      exp = {WL'(k + 1), 1'b1, (k != 0), 1'b0};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL single_word%0d got=%h required %h", k, got, exp);
      end
    end
    tick();
    tests++;
    if ({b0.streamvalid, b0.streamend, done0} !== 3'b001) begin
      fails++;
      $display("FAIL single_done got=%b required 001",
               {b0.streamvalid, b0.streamend, done0});
    end
    tick();
    tests++;
    if (done0 !== 1'b0) begin
      fails++;
      $display("FAIL single_done_pulse got=%b required 0", done0);
    end
    wait_idle();
  endtask

  task automatic test_repeat();
    logic [WL+1:0] got, exp;
    load(32'd5);
    load(32'd6);
    kick(2, 3);
    for (int k = 0; k < 6; k++) begin
      tick();
      got = {b0.streamvalue, b0.streamvalid, b0.streamend};
      exp = {((k % 2) != 0) ? 32'd6 : 32'd5, 1'b1, ((k % 2) != 0)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL repeat_word%0d got=%h required %h", k, got, exp);
      end
    end
    tick();
    tests++;
    if ({b0.streamvalid, done0} !== 2'b01) begin
      fails++;
      $display("FAIL repeat_done got=%b required 01",
               {b0.streamvalid, done0});
    end
    wait_idle();
  endtask

  task automatic test_skew();
    logic [WL+2:0] got, exp;
    load(32'd7);
    load(32'd8);
    kick(2, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (b3.streamvalid !== 1'b0) begin
        fails++;
        $display("FAIL skew_early%0d got=%b required 0", k, b3.streamvalid);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      got = {b3.streamvalue, b3.streamvalid, b3.streamend, done3};
      exp = {WL'(7 + k), 1'b1, (k != 0), 1'b0};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL skew_word%0d got=%h required %h", k, got, exp);
      end
    end
    tick();
    tests++;
    if ({b3.streamvalid, b3.streamend, done3} !== 3'b001) begin
      fails++;
      $display("FAIL skew_done got=%b required 001",
               {b3.streamvalid, b3.streamend, done3});
    end
    wait_idle();
  endtask

  task automatic test_reject();
    int lens [3] = '{1, 5, 4};
    int reps [3] = '{1, 1, 0};
    for (int i = 1; i <= 4; i++) load(WL'(i));
    for (int c = 0; c < 3; c++) begin
      cfg_len = LW'(lens[c]);
      cfg_rep = RW'(reps[c]);
      start = 1'b1;
      b0.load_valid = 1'b1;
      b0.load_data  = 32'd99;
      #1;
      tests++;
      if (b0.load_ready !== 1'b0) begin
        fails++;
        $display("FAIL reject%0d_ready got=%b required 0", c, b0.load_ready);
      end
      tick();
      start = 1'b0;
      b0.load_valid = 1'b0;
      tests++;
      if ({err0, err3, busy0, busy3, b0.streamvalid, b3.streamvalid}
          !== 6'b110000) begin
        fails++;
        $display("FAIL reject%0d_err got=%b required 110000", c,
                 {err0, err3, busy0, busy3, b0.streamvalid, b3.streamvalid});
      end
      tick();
      tests++;
      if ({err0, busy0, b0.streamvalid} !== 3'b000) begin
        fails++;
        $display("FAIL reject%0d_pulse got=%b required 000", c,
                 {err0, busy0, b0.streamvalid});
      end
    end
  endtask

  task automatic test_stall();
    logic [WL+1:0] got, exp;
    kick(4, 2);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        ena = 1'b0;
        for (int s = 0; s < 2; s++) begin
          tick();
          got = {b0.streamvalue, b0.streamvalid, b0.streamend};
          tests++;
          if (got !== {32'd2, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL stall_hold%0d got=%h required %h", s, got,
                     {32'd2, 1'b1, 1'b1});
          end
        end
        ena = 1'b1;
      end
      tick();
      got = {b0.streamvalue, b0.streamvalid, b0.streamend};
      exp = {WL'((k % 4) + 1), 1'b1, ((k % 4) != 0)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL stall_word%0d got=%h required %h", k, got, exp);
      end
    end
    tick();
    tests++;
    if ({b0.streamvalid, done0} !== 2'b01) begin
      fails++;
      $display("FAIL stall_done got=%b required 01", {b0.streamvalid, done0});
    end
    wait_idle();
  endtask

  task automatic test_overflow_reset();
    logic [WL+1:0] got, exp;
    for (int i = 0; i < ML + 2; i++) begin
      b0.load_valid = 1'b1;
      b0.load_data  = WL'(100 + i);
      #1;
      tests++;
      if (b0.load_ready !== (i < ML)) begin
        fails++;
        $display("FAIL overflow_ready%0d got=%b required %b", i,
                 b0.load_ready, (i < ML));
      end
      tick();
    end
    b0.load_valid = 1'b0;
    kick(ML, 2);
    for (int k = 0; k <= ML; k++) begin
      tick();
      got = {b0.streamvalue, b0.streamvalid, b0.streamend};
      exp = {WL'(100 + (k % ML)), 1'b1, ((k % ML) != 0)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL overflow_word%0d got=%h required %h", k, got, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({b0.streamvalid, b0.streamend, |b0.streamvalue, busy0, done0,
         b3.streamvalid, b3.streamend, |b3.streamvalue, busy3,
         b0.load_ready} !== 10'b0) begin
      fails++;
      $display("FAIL async_reset got=%b required 0",
               {b0.streamvalid, b0.streamend, |b0.streamvalue, busy0, done0,
                b3.streamvalid, b3.streamend, |b3.streamvalue, busy3,
                b0.load_ready});
    end
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if ({b0.load_ready, b3.load_ready, busy0, busy3} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_rearm got=%b required 1100",
               {b0.load_ready, b3.load_ready, busy0, busy3});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_skew();
    test_reject();
    test_stall();
    test_overflow_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
